// File: rtl/uv_pred_sched.sv
// Chroma (U/V 8x8) intra predictor sequencer: picks the applicable modes per macroblock,
// starts each predictor in turn and hands finished predictions to the mode scorer.
//
// state  | meaning
// IDLE   | waiting for a macroblock; mb_ready high
// ISSUE  | one-cycle start pulse to the selected predictor; timer loaded
// WAIT   | waiting for pred_done; timer counts down to terminal count
// HOLD   | result offered to the scorer until res_ready
// NEXT   | advance to the next enabled mode, or finish
// FINISH | one-cycle mb_done pulse
module uv_pred_sched #(
  parameter int       BLOCK_NUM    = 10,
  parameter bit [3:0] MODE_EN      = 4'b1111,
  parameter bit       SKIP_UNAVAIL = 1'b1,
  parameter int       TIMEOUT_CYC  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mb_valid,
  output logic                 mb_ready,
  input  logic [BLOCK_NUM-1:0] mb_x,
  input  logic [BLOCK_NUM-1:0] mb_y,
  output logic                 pred_start,
  output logic [1:0]           pred_mode,
  output logic [BLOCK_NUM-1:0] pred_x,
  output logic [BLOCK_NUM-1:0] pred_y,
  input  logic                 pred_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [1:0]           res_mode,
  output logic                 res_last,
  output logic                 mb_done,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, HOLD, NEXT, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [3:1]    mask_q;
  logic [TW-1:0] tmr_q;
  logic          accept;
  logic          tmr_tc;
  logic          nxt_found;
  logic [1:0]    nxt_mode;

  assign accept   = mb_valid & mb_ready;
  assign tmr_tc   = (tmr_q == '0);
  assign res_mode = pred_mode;

  // Lowest enabled mode above the current one; DC is always first so it never appears here.
  always_comb begin
    nxt_found = 1'b0;
    nxt_mode  = pred_mode;
    for (int i = 3; i >= 1; i--) begin
      if (i > int'(pred_mode) && mask_q[i]) begin
        nxt_found = 1'b1;
        nxt_mode  = 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (pred_done)   state_d = HOLD;
        else if (tmr_tc) state_d = NEXT;
      end
      HOLD:    if (res_ready) state_d = NEXT;
      NEXT:    state_d = nxt_found ? ISSUE : FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      pred_mode   <= '0;
      pred_x      <= '0;
      pred_y      <= '0;
      tmr_q       <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        pred_x    <= mb_x;
        pred_y    <= mb_y;
        pred_mode <= 2'd0;
        mask_q[1] <= MODE_EN[1];
        mask_q[2] <= MODE_EN[2] & ((mb_y != '0) | !SKIP_UNAVAIL);
        mask_q[3] <= MODE_EN[3] & ((mb_x != '0) | !SKIP_UNAVAIL);
      end
      if (state_q == NEXT && nxt_found) pred_mode <= nxt_mode;
      if (state_q == ISSUE) tmr_q <= TMR_LOAD;
      else if (state_q == WAIT && !tmr_tc) tmr_q <= tmr_q - 1'b1;
      // A done arriving on the terminal-count cycle wins over the timeout.
      if (state_q == WAIT && !pred_done && tmr_tc) err_timeout <= 1'b1;
    end
  end

  // Outputs registered from the next state so nothing combinational reaches the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_ready   <= 1'b0;
      busy       <= 1'b0;
      pred_start <= 1'b0;
      res_valid  <= 1'b0;
      res_last   <= 1'b0;
      mb_done    <= 1'b0;
    end else begin
      mb_ready   <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      pred_start <= (state_d == ISSUE);
      res_valid  <= (state_d == HOLD);
      res_last   <= (state_d == HOLD) && !nxt_found;
      mb_done    <= (state_d == FINISH);
    end
  end

endmodule

// File: tb/tb_uv_pred_sched.sv
// Scoreboard bench for uv_pred_sched: stimulus queues expected starts/results,
// a monitor pops and compares them as the DUT presents them.
module tb_uv_pred_sched;

  localparam int BN = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mb_valid = 1'b0;
  logic          mb_ready;
  logic [BN-1:0] mb_x = '0;
  logic [BN-1:0] mb_y = '0;
  logic          pred_start;
  logic [1:0]    pred_mode;
  logic [BN-1:0] pred_x;
  logic [BN-1:0] pred_y;
  logic          pred_done = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [1:0]    res_mode;
  logic          res_last;
  logic          mb_done;
  logic          busy;
  logic          err_timeout;

  uv_pred_sched #(
    .BLOCK_NUM(BN), .MODE_EN(4'b1111), .SKIP_UNAVAIL(1'b1), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mb_valid(mb_valid), .mb_ready(mb_ready), .mb_x(mb_x), .mb_y(mb_y),
    .pred_start(pred_start), .pred_mode(pred_mode), .pred_x(pred_x), .pred_y(pred_y),
    .pred_done(pred_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_mode(res_mode), .res_last(res_last),
    .mb_done(mb_done), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic          last;
    logic [BN-1:0] x;
    logic [BN-1:0] y;
  } exp_t;

  exp_t sq[$];
  exp_t rq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   exp_done = 0;
  int   done_dly = 2;
  int   hang_mode = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_s(input logic [1:0] m, input logic [BN-1:0] x, input logic [BN-1:0] y);
    exp_t t;
    t.mode = m; t.last = 1'b0; t.x = x; t.y = y;
    sq.push_back(t);
  endtask

  task automatic push_r(input logic [1:0] m, input logic l, input logic [BN-1:0] x,
                        input logic [BN-1:0] y);
    exp_t t;
    t.mode = m; t.last = l; t.x = x; t.y = y;
    rq.push_back(t);
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (pred_start) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start actual_mode=%0d required=none", pred_mode);
        end else begin
          e = sq.pop_front();
          chk("start_mode", 32'(pred_mode), 32'(e.mode));
          chk("start_x", 32'(pred_x), 32'(e.x));
          chk("start_y", 32'(pred_y), 32'(e.y));
        end
      end
      if (res_valid && res_ready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual_mode=%0d required=none", res_mode);
        end else begin
          e = rq.pop_front();
          chk("res_mode", 32'(res_mode), 32'(e.mode));
          chk("res_last", 32'(res_last), 32'(e.last));
          chk("res_x", 32'(pred_x), 32'(e.x));
          chk("res_y", 32'(pred_y), 32'(e.y));
        end
      end
      if (mb_done) done_seen++;
    end
  end

  // Predictor model: done pulse done_dly cycles after start, never for hang_mode.
  always begin
    @(negedge clk);
    if (rst_n && pred_start && int'(pred_mode) != hang_mode) begin
      repeat (done_dly) @(negedge clk);
      pred_done = 1'b1;
      @(negedge clk);
      pred_done = 1'b0;
    end
  end

  task automatic send_mb(input logic [BN-1:0] x, input logic [BN-1:0] y);
    int n;
    n = 0;
    while (!mb_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mb_ready_wait", 32'(mb_ready), 32'd1);
    mb_valid = 1'b1;
    mb_x = x;
    mb_y = y;
    @(negedge clk);
    mb_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mb_done && n < 300);
    chk("mb_done_seen", 32'(mb_done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic end_check(input string name);
    chk({name, "_starts_left"}, 32'(sq.size()), 32'd0);
    chk({name, "_results_left"}, 32'(rq.size()), 32'd0);
    chk({name, "_mb_done_count"}, 32'(done_seen), 32'(exp_done));
  endtask

  initial begin
    int n;
    logic ok;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("reset_outs", {1'b0, mb_ready, pred_start, pred_mode, pred_x, pred_y, res_valid,
                       res_mode, res_last, mb_done, busy, err_timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(mb_ready), 32'd1);
    chk("post_reset_outs", {2'b0, pred_start, pred_mode, pred_x, pred_y, res_valid,
                            res_mode, res_last, mb_done, busy, err_timeout}, 32'd0);

    // All four modes, x=5 y=3
    for (int m = 0; m < 4; m++) push_s(2'(m), 10'd5, 10'd3);
    push_r(2'd0, 1'b0, 10'd5, 10'd3);
    push_r(2'd1, 1'b0, 10'd5, 10'd3);
    push_r(2'd2, 1'b0, 10'd5, 10'd3);
    push_r(2'd3, 1'b1, 10'd5, 10'd3);
    exp_done++;
    send_mb(10'd5, 10'd3);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_done();
    end_check("all_modes");

    // Corner block: no neighbours, DC and TM only
    push_s(2'd0, 10'd0, 10'd0);
    push_s(2'd1, 10'd0, 10'd0);
    push_r(2'd0, 1'b0, 10'd0, 10'd0);
    push_r(2'd1, 1'b1, 10'd0, 10'd0);
    exp_done++;
    send_mb(10'd0, 10'd0);
    wait_done();
    end_check("corner");

    // Top row, scorer stalls mode 0; VE skipped
    res_ready = 1'b0;
    push_s(2'd0, 10'd4, 10'd0);
    push_s(2'd1, 10'd4, 10'd0);
    push_s(2'd3, 10'd4, 10'd0);
    push_r(2'd0, 1'b0, 10'd4, 10'd0);
    push_r(2'd1, 1'b0, 10'd4, 10'd0);
    push_r(2'd3, 1'b1, 10'd4, 10'd0);
    exp_done++;
    send_mb(10'd4, 10'd0);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", 32'(res_valid), 32'd1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || res_mode != 2'd0) ok = 1'b0;
    end
    chk("stall_hold_stable", 32'(ok), 32'd1);
    res_ready = 1'b1;
    wait_done();
    end_check("stall");

    // Predictor for TM never answers
    hang_mode = 1;
    for (int m = 0; m < 4; m++) push_s(2'(m), 10'd2, 10'd2);
    push_r(2'd0, 1'b0, 10'd2, 10'd2);
    push_r(2'd2, 1'b0, 10'd2, 10'd2);
    push_r(2'd3, 1'b1, 10'd2, 10'd2);
    exp_done++;
    chk("err_before_timeout", 32'(err_timeout), 32'd0);
    send_mb(10'd2, 10'd2);
    n = 0;
    while (!(pred_start && pred_mode == 2'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tm_start_seen", 32'(pred_start && pred_mode == 2'd1), 32'd1);
    n = 0;
    while (!err_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    // 1 ISSUE cycle + 8 WAIT cycles before the flag shows
    chk("timeout_latency", 32'(n), 32'd9);
    wait_done();
    end_check("timeout");
    chk("err_sticky", 32'(err_timeout), 32'd1);
    hang_mode = 4;

    // Reset during HOLD of VE
    push_s(2'd0, 10'd1, 10'd1);
    push_s(2'd1, 10'd1, 10'd1);
    push_s(2'd2, 10'd1, 10'd1);
    push_r(2'd0, 1'b0, 10'd1, 10'd1);
    push_r(2'd1, 1'b0, 10'd1, 10'd1);
    send_mb(10'd1, 10'd1);
    n = 0;
    while (!(pred_start && pred_mode == 2'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ve_hold_mode", 32'(res_mode), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_res_valid", 32'(res_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_err_clear", 32'(err_timeout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (mb_done || res_valid || busy) ok = 1'b0;
    end
    chk("quiet_after_reset", 32'(ok), 32'd1);
    end_check("reset_abort");
    res_ready = 1'b1;
    for (int m = 0; m < 4; m++) push_s(2'(m), 10'd3, 10'd7);
    push_r(2'd0, 1'b0, 10'd3, 10'd7);
    push_r(2'd1, 1'b0, 10'd3, 10'd7);
    push_r(2'd2, 1'b0, 10'd3, 10'd7);
    push_r(2'd3, 1'b1, 10'd3, 10'd7);
    exp_done++;
    send_mb(10'd3, 10'd7);
    wait_done();
    end_check("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
